udp_tx_packer: RTL
==================

UDP_TX_PACKER -- requirements
Module: udp_tx_packer

Interface
REQ-001 Parameter MAX_PAYLOAD, default 1472, SHALL set the maximum payload bytes per packet (range 2-1472).
REQ-002 Parameter IDLE_TIMEOUT, default 1024, SHALL set the logic_clk cycles without new input before an open packet is closed (range 2-65535).
REQ-003 Port logic_clk, input, 1: the single clock for all logic.
REQ-004 Port logic_rstn, input, 1: asynchronous, active-low reset.
REQ-005 Port user_tdata_in, input, 8: user byte stream.
REQ-006 Port user_tvalid_in, input, 1: user byte valid.
REQ-007 Port user_tready_out, output, 1: block accepts a user byte.
REQ-008 Port user_tflush_in, input, 1: one-cycle request to close the open packet.
REQ-009 Port dest_ip_in, input, 32: destination IP, sampled per packet.
REQ-010 Port udp_tdata_out, output, 8: payload byte toward the transport layer.
REQ-011 Port udp_tvalid_out, output, 1: payload byte valid.
REQ-012 Port udp_tready_in, input, 1: transport layer accepts a byte.
REQ-013 Port udp_tlast_out, output, 1: marks the final byte of a packet.
REQ-014 Port udp_tip_out, output, 32: destination IP, held constant for a whole packet.
REQ-015 Port pkt_count_out, output, 16: count of completed packets; wraps 0xFFFF -> 0.

Function
REQ-016 A transfer SHALL occur on any edge where valid and ready are both high; valid, data, last and ip SHALL NOT change while valid is high and ready is low.
REQ-017 The datapath SHALL be two registers in series: hold (h_data, h_valid), then output (udp_tdata_out, udp_tvalid_out, udp_tlast_out).
REQ-018 The output slot SHALL be free when udp_tvalid_out is 0 or udp_tready_in is 1.
REQ-019 user_tready_out SHALL be combinational: (state==S_EMPTY) or (state==S_HOLD and output slot free).
REQ-020 The FSM SHALL have three states:
- S_EMPTY: no held byte.
- S_HOLD: one held byte, packet open.
- S_CLOSE: held byte is final and waits for a free output slot.
REQ-021 S_EMPTY + user transfer: the byte goes to hold, dest_ip_in is latched into udp_tip_out, byte_cnt=1, idle_cnt=0, next state S_HOLD.
REQ-022 S_HOLD + user transfer with byte_cnt < MAX_PAYLOAD: the held byte moves to output with last=0, the new byte goes to hold, byte_cnt increments, idle_cnt=0.
REQ-023 When byte_cnt reaches MAX_PAYLOAD, the next state SHALL be S_CLOSE, so a packet never exceeds MAX_PAYLOAD bytes.
REQ-024 In S_HOLD with no user transfer, idle_cnt SHALL increment (saturating); idle_cnt==IDLE_TIMEOUT-1 or user_tflush_in=1 SHALL give next state S_CLOSE.
REQ-025 S_CLOSE with output slot free: the held byte moves to output with last=1, pkt_count_out increments, next state S_EMPTY; user_tready_out is 0 throughout S_CLOSE.
REQ-026 Flush and a user transfer in the same S_HOLD cycle: the transfer SHALL complete first, then the new held byte closes the packet (next state S_CLOSE).
REQ-027 user_tflush_in in S_EMPTY or S_CLOSE SHALL be ignored; zero-length packets SHALL never be emitted.
REQ-028 udp_tip_out SHALL change only on the S_EMPTY -> S_HOLD transition.
REQ-029 Throughput SHALL be one byte per cycle while udp_tready_in=1; latency from user byte to udp_tdata_out is one cycle after the next byte arrives, or after close.

Reset
REQ-030 While logic_rstn=0, the following SHALL be forced immediately and asynchronously:
- state=S_EMPTY; h_valid=0; byte_cnt=0; idle_cnt=0.
- udp_tvalid_out=0, udp_tlast_out=0, udp_tdata_out=0, udp_tip_out=0, pkt_count_out=0.
REQ-031 Reset mid-packet SHALL discard held and output bytes without asserting udp_tlast_out; the first packet after reset starts fresh.

Structure
REQ-032 FSM state enum, MAX_PAYLOAD/IDLE_TIMEOUT defaults and counter widths SHALL live in the shared eth package (eth_pkg).
REQ-033 The block SHALL be a single module with no sub-modules; counters SHALL be sized by $clog2 of their parameters.

Verification
REQ-034 Bytes 0x01..0x05 back-to-back, udp_tready_in=1, IDLE_TIMEOUT=16 -> one packet 01..05, last on 0x05 exactly 16 cycles after 0x05 was accepted, pkt_count_out=1.
REQ-035 MAX_PAYLOAD=4, 10 continuous bytes -> packets of 4, 4, 2 (the last closed by timeout), tlast on bytes 4, 8 and 10, and user_tready_out low one cycle after bytes 4 and 8.
REQ-036 udp_tready_in toggled 1/0 every cycle with random user_tvalid_in -> byte order preserved, no loss or duplication, outputs stable while stalled.
REQ-037 user_tflush_in together with byte 0x33, then dest_ip_in changed to 0xC0A80001 -> 0x33 carries tlast, and the next packet carries udp_tip_out=0xC0A80001.
REQ-038 logic_rstn pulsed low mid-packet after 3 bytes -> all outputs 0 within the reset, no tlast emitted, a subsequent 2-byte packet is correct and pkt_count_out=1.
REQ-039 user_tflush_in while in S_EMPTY -> no output activity, pkt_count_out unchanged.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet/UDP transmit definitions: packer FSM states, parameter
// defaults and counter sizing helpers.
package eth_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_CLOSE = 2'd2
    } pkt_state_e;

    localparam int MAX_PAYLOAD_DEF  = 1472;
    localparam int IDLE_TIMEOUT_DEF = 1024;

    // Byte counter must hold the value MAX_PAYLOAD itself.
    function automatic int byte_cnt_w(input int max_payload);
        return $clog2(max_payload + 1);
    endfunction

    // Idle counter only ever needs to reach IDLE_TIMEOUT-1.
    function automatic int idle_cnt_w(input int idle_timeout);
        return $clog2(idle_timeout);
    endfunction

    localparam int BYTE_CNT_W_DEF = byte_cnt_w(MAX_PAYLOAD_DEF);
    localparam int IDLE_CNT_W_DEF = idle_cnt_w(IDLE_TIMEOUT_DEF);

endpackage

// File: rtl/udp_tx_packer.sv
// Packs a user byte stream into UDP payload packets. One byte is always held
// back so that the final byte of a packet can be tagged with tlast when the
// packet closes (size limit, idle timeout or flush).
//
// state   | meaning
// S_EMPTY | no held byte, waiting for the first byte of a packet
// S_HOLD  | one held byte, packet open
// S_CLOSE | held byte is the final one, waiting for a free output slot
module udp_tx_packer
    import eth_pkg::*;
#(
    parameter int MAX_PAYLOAD  = MAX_PAYLOAD_DEF,
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic        logic_clk,
    input  logic        logic_rstn,
    input  logic [7:0]  user_tdata_in,
    input  logic        user_tvalid_in,
    output logic        user_tready_out,
    input  logic        user_tflush_in,
    input  logic [31:0] dest_ip_in,
    output logic [7:0]  udp_tdata_out,
    output logic        udp_tvalid_out,
    input  logic        udp_tready_in,
    output logic        udp_tlast_out,
    output logic [31:0] udp_tip_out,
    output logic [15:0] pkt_count_out
);

    localparam int BCW = byte_cnt_w(MAX_PAYLOAD);
    localparam int IDW = idle_cnt_w(IDLE_TIMEOUT);
    localparam logic [BCW-1:0] BC_MAX    = BCW'(MAX_PAYLOAD);
    localparam logic [IDW-1:0] IDLE_LAST = IDW'(IDLE_TIMEOUT - 1);

    pkt_state_e     state_q, state_d;
    logic [7:0]     h_data_q, h_data_d;
    logic           h_valid_q, h_valid_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [IDW-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic [31:0]    ip_q, ip_d;
    logic [15:0]    pkt_cnt_q, pkt_cnt_d;

    logic slot_free;
    logic user_ready;
    logic user_xfer;

    assign slot_free  = !out_valid_q || udp_tready_in;
    assign user_ready = (state_q == S_EMPTY) || ((state_q == S_HOLD) && slot_free);
    assign user_xfer  = user_tvalid_in && user_ready;

    // Next-state and datapath: hold register feeds the output register.
    always_comb begin
        state_d     = state_q;
        h_data_d    = h_data_q;
        h_valid_d   = h_valid_q;
        byte_cnt_d  = byte_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        ip_d        = ip_q;
        pkt_cnt_d   = pkt_cnt_q;

        // A consumed (or empty) output slot empties unless refilled below.
        if (slot_free) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_EMPTY: begin
                if (user_xfer) begin
                    h_data_d   = user_tdata_in;
                    h_valid_d  = 1'b1;
                    ip_d       = dest_ip_in;
                    byte_cnt_d = BCW'(1);
                    idle_cnt_d = '0;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (user_xfer) begin
                    out_data_d  = h_data_q;
                    out_valid_d = h_valid_q;
                    out_last_d  = 1'b0;
                    h_data_d    = user_tdata_in;
                    byte_cnt_d  = byte_cnt_q + BCW'(1);
                    idle_cnt_d  = '0;
                    // Flush with a simultaneous byte closes on the new byte.
                    if ((byte_cnt_d == BC_MAX) || user_tflush_in) begin
                        state_d = S_CLOSE;
                    end
                end else begin
                    if (idle_cnt_q != IDLE_LAST) begin
                        idle_cnt_d = idle_cnt_q + IDW'(1);
                    end
                    if ((idle_cnt_d == IDLE_LAST) || user_tflush_in) begin
                        state_d = S_CLOSE;
                    end
                end
            end
            S_CLOSE: begin
                if (slot_free) begin
                    out_data_d  = h_data_q;
                    out_valid_d = h_valid_q;
                    out_last_d  = 1'b1;
                    h_valid_d   = 1'b0;
                    byte_cnt_d  = '0;
                    idle_cnt_d  = '0;
                    pkt_cnt_d   = pkt_cnt_q + 16'd1;
                    state_d     = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge logic_clk or negedge logic_rstn) begin
        if (!logic_rstn) begin
            state_q     <= S_EMPTY;
            h_data_q    <= '0;
            h_valid_q   <= 1'b0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ip_q        <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            h_data_q    <= h_data_d;
            h_valid_q   <= h_valid_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            ip_q        <= ip_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign user_tready_out = user_ready;
    assign udp_tdata_out   = out_data_q;
    assign udp_tvalid_out  = out_valid_q;
    assign udp_tlast_out   = out_last_q;
    assign udp_tip_out     = ip_q;
    assign pkt_count_out   = pkt_cnt_q;

endmodule
